// File: rtl/odd_parity_serial_tx.sv
// Serial transmitter for a data word plus odd-parity bit: start, data LSB first, parity, stop.
// Recomputes odd parity on accept and flags disagreement with the upstream parity bit.
module odd_parity_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              par_mismatch,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Handshake: a word is taken on any rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_valid elsewhere has no effect.
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W:0]   shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              mism_q, mism_d;
  logic              accept;
  logic              bit_end;

  assign accept  = in_valid && (state_q == S_IDLE);
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    mism_d  = mism_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = {parity_in, data_in};
          tx_d    = 1'b0;
          mism_d  = (parity_in != ~^data_in);
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_W:1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        // The shift register holds the parity bit above the data, so the
        // final data-bit wrap naturally drives the parity bit onto tx.
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_W:1]};
          if (idx_q == IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      mism_q  <= mism_d;
    end
  end

  assign tx           = tx_q;
  assign busy         = (state_q != S_IDLE);
  assign in_ready     = (state_q == S_IDLE);
  assign done         = done_q;
  assign par_mismatch = mism_q;
  assign dbg_state    = state_q;

endmodule
